mips_multicycle_control: RTL and testbench

Multicycle controller for the MIPS core. It sequences the shared datapath (register file, ALU, unified instruction/data memory, PC and IR registers) one instruction at a time through a Moore state machine. It produces every datapath select and enable, including the register-file write enable `WE3`, and stalls on memory through a ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/mips_multicycle_control_if.sv | 35 +++
 rtl/mips_multicycle_control_alu_decoder.sv | 30 +++
 rtl/mips_multicycle_control.sv | 134 +++++++++++++
 tb/tb_mips_multicycle_control.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs, ALU and mux codes.
// No logic here; imported by the controller, its ALU decoder and the bench.
package mips_ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave the datapath.
// Pure wiring, no latency; MemReady is the only backpressure signal carried.
interface mips_multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               Zero;
  logic               MemReady;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUControl;
  logic [1:0]         PCSrc;
  logic               PCEn;
  logic               Illegal;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCEn, Illegal, State
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCEn, Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_control_alu_decoder.sv
// Maps Funct plus state context to ALUControl and flags whether Funct is a supported R-type op.
// Purely combinational; no backpressure.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic       exec_i,
  input  logic       branch_i,
  output logic [2:0] alu_control_o,
  output logic       funct_valid_o
);
  logic [2:0] funct_alu;

  always_comb begin
    funct_alu     = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_SLT:   funct_alu = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

  // Funct only matters in EXECUTE; BRANCH compares by subtraction, everything else adds.
  assign alu_control_o = exec_i   ? funct_alu :
                         branch_i ? ALU_SUB   : ALU_ADD;
endmodule

// File: rtl/mips_multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath; outputs decode the current state.
// Illegal is registered (pulses in the FETCH after decode); holds in FETCH/MEMREAD/MEMWRITE while MemReady=0.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input logic                       clk,
  input logic                       reset,
  mips_multicycle_control_if.master bus
);
  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] alu_ctrl;
  logic       funct_valid;

  alu_decoder u_alu_decoder (
    .funct_i       (bus.Funct),
    .exec_i        (state_q == S_EXECUTE),
    .branch_i      (state_q == S_BRANCH),
    .alu_control_o (alu_ctrl),
    .funct_valid_o (funct_valid)
  );

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:    state_d = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      illegal_d = 1'b1;
        endcase
      end
      S_MEMADR:   state_d = (bus.Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = bus.MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = bus.MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTE: begin
        if (funct_valid) state_d = S_ALUWB;
        else             illegal_d = 1'b1;
      end
      S_ADDIEX:   state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en;
  logic [1:0] alu_src_b, pc_src;

  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PC_ALURES;
    pc_en      = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Reset also holds the state in FETCH, so gating here masks the enables during reset.
        alu_src_b = SRCB_FOUR;
        ir_write  = reset & bus.MemReady;
        pc_en     = reset & bus.MemReady;
      end
      S_DECODE:   alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE:  alu_src_a = 1'b1;
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PC_ALUOUT;
        pc_en     = bus.Zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB:   reg_write = 1'b1;
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.IorD       = iord;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.RegWrite   = reg_write;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctrl;
  assign bus.PCSrc      = pc_src;
  assign bus.PCEn       = pc_en;
  assign bus.Illegal    = illegal_q;
  assign bus.State      = STATE_W'(state_q);
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS controller: per-cycle state and output-vector checks.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  mips_multicycle_control_if #(.STATE_W(4)) bus ();

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA}_ALUSrcB_ALUControl_PCSrc_PCEn_Illegal
  logic [15:0] outs;
  assign outs = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                 bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                 bus.PCSrc, bus.PCEn, bus.Illegal};

  localparam logic [15:0] E_FETCH_RDY  = 16'b0010000_01_010_00_1_0;
  localparam logic [15:0] E_FETCH_WAIT = 16'b0000000_01_010_00_0_0;
  localparam logic [15:0] E_FETCH_ILL  = 16'b0010000_01_010_00_1_1;
  localparam logic [15:0] E_DECODE     = 16'b0000000_11_010_00_0_0;
  localparam logic [15:0] E_MEMADR     = 16'b0000001_10_010_00_0_0;
  localparam logic [15:0] E_MEMREAD    = 16'b1000000_00_010_00_0_0;
  localparam logic [15:0] E_MEMWB      = 16'b0000110_00_010_00_0_0;
  localparam logic [15:0] E_MEMWRITE   = 16'b1100000_00_010_00_0_0;
  localparam logic [15:0] E_EXEC_ADD   = 16'b0000001_00_010_00_0_0;
  localparam logic [15:0] E_ALUWB      = 16'b0001010_00_010_00_0_0;
  localparam logic [15:0] E_BR_T       = 16'b0000001_00_110_01_1_0;
  localparam logic [15:0] E_BR_N       = 16'b0000001_00_110_01_0_0;
  localparam logic [15:0] E_ADDIEX     = 16'b0000001_10_010_00_0_0;
  localparam logic [15:0] E_ADDIWB     = 16'b0000010_00_010_00_0_0;
  localparam logic [15:0] E_JUMP       = 16'b0000000_00_010_10_1_0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    state_t es [3] = '{S_DECODE, S_JUMP, S_FETCH};
    logic [15:0] eo [3] = '{E_DECODE, E_JUMP, E_FETCH_RDY};
    reset = 1'b0; bus.MemReady = 1'b1; bus.Op = OP_J; bus.Funct = 6'd0; bus.Zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.State !== S_FETCH || outs !== E_FETCH_WAIT)
        $display("FAIL reset_hold: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_FETCH, E_FETCH_WAIT);
      else passes++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.State !== S_FETCH || outs !== E_FETCH_RDY)
      $display("FAIL reset_release: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_FETCH, E_FETCH_RDY);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.State !== es[i] || outs !== eo[i])
        $display("FAIL jump_c%0d: state=%0d outs=%b, want state=%0d outs=%b", i, bus.State, outs, es[i], eo[i]);
      else passes++;
    end
  endtask

  task automatic test_rtype();
    state_t es [4] = '{S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB};
    logic [15:0] eo [4] = '{E_FETCH_RDY, E_DECODE, E_EXEC_ADD, E_ALUWB};
    bus.Op = OP_RTYPE; bus.Funct = 6'b100000; bus.MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.State !== es[i] || outs !== eo[i])
        $display("FAIL rtype_c%0d: state=%0d outs=%b, want state=%0d outs=%b", i, bus.State, outs, es[i], eo[i]);
      else passes++;
      tick();
    end
    checks++;
    if (bus.State !== S_FETCH) $display("FAIL rtype_end: state=%0d, want %0d", bus.State, S_FETCH);
    else passes++;
  endtask

  task automatic test_lw();
    logic   mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    state_t es [8] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
    logic [15:0] eo [8] = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB};
    bus.Op = OP_LW;
    for (int i = 0; i < 8; i++) begin
      bus.MemReady = mr[i];
      #1;
      checks++;
      if (bus.State !== es[i] || outs !== eo[i])
        $display("FAIL lw_c%0d: state=%0d outs=%b, want state=%0d outs=%b", i, bus.State, outs, es[i], eo[i]);
      else passes++;
      tick();
    end
    bus.MemReady = 1'b1;
    checks++;
    if (bus.State !== S_FETCH) $display("FAIL lw_end: state=%0d, want %0d", bus.State, S_FETCH);
    else passes++;
  endtask

  task automatic test_sw_stall();
    logic   mr [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    state_t es [6] = '{S_FETCH, S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE};
    logic [15:0] eo [6] = '{E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMWRITE, E_MEMWRITE};
    bus.Op = OP_SW;
    for (int i = 0; i < 6; i++) begin
      bus.MemReady = mr[i];
      #1;
      checks++;
      if (bus.State !== es[i] || outs !== eo[i])
        $display("FAIL sw_c%0d: state=%0d outs=%b, want state=%0d outs=%b", i, bus.State, outs, es[i], eo[i]);
      else passes++;
      tick();
    end
    checks++;
    if (bus.State !== S_FETCH) $display("FAIL sw_end: state=%0d, want %0d", bus.State, S_FETCH);
    else passes++;
  endtask

  task automatic test_beq();
    logic   zr [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    state_t es [6] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_BRANCH};
    logic [15:0] eo [6] = '{E_FETCH_RDY, E_DECODE, E_BR_T, E_FETCH_RDY, E_DECODE, E_BR_N};
    bus.Op = OP_BEQ; bus.MemReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.Zero = zr[i];
      #1;
      checks++;
      if (bus.State !== es[i] || outs !== eo[i])
        $display("FAIL beq_c%0d: state=%0d outs=%b, want state=%0d outs=%b", i, bus.State, outs, es[i], eo[i]);
      else passes++;
      tick();
    end
    bus.Zero = 1'b0;
    checks++;
    if (bus.State !== S_FETCH) $display("FAIL beq_end: state=%0d, want %0d", bus.State, S_FETCH);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ac [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    bus.Op = OP_RTYPE; bus.MemReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.Funct = fn[k];
      tick();
      tick();
      checks++;
      if (bus.State !== S_EXECUTE || bus.ALUControl !== ac[k])
        $display("FAIL funct_%b: state=%0d alu=%b, want state=%0d alu=%b", fn[k], bus.State, bus.ALUControl, S_EXECUTE, ac[k]);
      else passes++;
      tick();
      tick();
    end
    checks++;
    if (bus.State !== S_FETCH) $display("FAIL b2b_end: state=%0d, want %0d", bus.State, S_FETCH);
    else passes++;
  endtask

  task automatic test_illegal();
    bus.Op = 6'b111111; bus.MemReady = 1'b1;
    tick();
    checks++;
    if (bus.State !== S_DECODE || outs !== E_DECODE)
      $display("FAIL ill_op_decode: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_DECODE, E_DECODE);
    else passes++;
    tick();
    checks++;
    if (bus.State !== S_FETCH || outs !== E_FETCH_ILL)
      $display("FAIL ill_op_pulse: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_FETCH, E_FETCH_ILL);
    else passes++;
    bus.Op = OP_RTYPE; bus.Funct = 6'b000111;
    tick();
    checks++;
    if (bus.State !== S_DECODE || outs !== E_DECODE)
      $display("FAIL ill_pulse_end: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_DECODE, E_DECODE);
    else passes++;
    tick();
    checks++;
    if (bus.State !== S_EXECUTE || bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0 || bus.Illegal !== 1'b0)
      $display("FAIL ill_fn_exec: state=%0d rw=%b mw=%b ill=%b, want state=%0d rw=0 mw=0 ill=0",
               bus.State, bus.RegWrite, bus.MemWrite, bus.Illegal, S_EXECUTE);
    else passes++;
    tick();
    checks++;
    if (bus.State !== S_FETCH || outs !== E_FETCH_ILL)
      $display("FAIL ill_fn_pulse: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_FETCH, E_FETCH_ILL);
    else passes++;
    bus.Op = OP_J;
    tick();
    tick();
    checks++;
    if (bus.State !== S_JUMP || outs !== E_JUMP)
      $display("FAIL ill_recover: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_JUMP, E_JUMP);
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.Op = OP_SW; bus.MemReady = 1'b1;
    tick(); tick(); tick();
    bus.MemReady = 1'b0;
    #1;
    checks++;
    if (bus.State !== S_MEMWRITE || bus.MemWrite !== 1'b1)
      $display("FAIL rst_sw_pre: state=%0d mw=%b, want state=%0d mw=1", bus.State, bus.MemWrite, S_MEMWRITE);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.State !== S_FETCH || outs !== E_FETCH_WAIT)
      $display("FAIL rst_sw_drop: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_FETCH, E_FETCH_WAIT);
    else passes++;
    bus.MemReady = 1'b1;
    tick();
    checks++;
    if (bus.State !== S_FETCH || outs !== E_FETCH_WAIT)
      $display("FAIL rst_hold: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_FETCH, E_FETCH_WAIT);
    else passes++;
    reset = 1'b1; bus.Op = OP_ADDI;
    tick(); tick();
    checks++;
    if (bus.State !== S_ADDIEX || outs !== E_ADDIEX)
      $display("FAIL addiex: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_ADDIEX, E_ADDIEX);
    else passes++;
    tick();
    checks++;
    if (bus.State !== S_ADDIWB || outs !== E_ADDIWB)
      $display("FAIL addiwb: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_ADDIWB, E_ADDIWB);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.State !== S_FETCH || bus.RegWrite !== 1'b0 || outs !== E_FETCH_WAIT)
      $display("FAIL rst_addi_drop: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_FETCH, E_FETCH_WAIT);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.State !== S_FETCH || outs !== E_FETCH_RDY)
      $display("FAIL rst_addi_release: state=%0d outs=%b, want state=%0d outs=%b", bus.State, outs, S_FETCH, E_FETCH_RDY);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw_stall();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "timeout");
  end
endmodule
